// File: rtl/qsys_epcs_nios2_oci_dct_pkg.sv
// Shared constants and encodings for the OCI data-compression-trace atom packer.
// Holds the packer state encoding, buffer geometry and 2-bit atom codes.
package qsys_epcs_nios2_oci_dct_pkg;

    localparam int SLOTS  = 15;
    localparam int CNT_W  = 4;
    localparam int ATOM_W = 2;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_FLUSH      = 2'd1,
        ST_STOP_DRAIN = 2'd2,
        ST_STOPPED    = 2'd3
    } dct_state_t;

    typedef enum logic [ATOM_W-1:0] {
        ATOM_C0 = 2'd0,
        ATOM_C1 = 2'd1,
        ATOM_C2 = 2'd2,
        ATOM_C3 = 2'd3
    } atom_code_t;

endpackage

// File: rtl/qsys_epcs_nios2_oci_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant among instruction and data trace requests.
// Latency: grant is combinational from requests; pointer advances one cycle after acceptance.
// Backpressure: pointer holds while the granted request is not accepted.
module qsys_epcs_nios2_oci_rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    // Set when the data requester won last, so the instruction requester is favoured next.
    logic last_dt;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_dt ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_dt <= 1'b1;
        end else if (accept) begin
            last_dt <= grant[1];
        end
    end

endmodule

// File: rtl/qsys_epcs_nios2_oci_dct_packer.sv
// Packs 2-bit trace atoms from two requesters into 15-slot words for the OCI trace FIFO.
// Latency: word valid two cycles after the 15th atom or a flush request, if the output is free.
// Backpressure: a held output word stalls transfer; readys drop once the accumulator is full.
module qsys_epcs_nios2_oci_dct_packer #(
    parameter int SLOTS = 15,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               it_valid,
    input  logic [1:0]         it_atom,
    output logic               it_ready,
    input  logic               dt_valid,
    input  logic [1:0]         dt_atom,
    output logic               dt_ready,
    input  logic               flush,
    input  logic               trace_stop,
    input  logic               trace_start,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*SLOTS-1:0] dct_buffer,
    output logic [CNT_W-1:0]   dct_count,
    output logic               test_ending,
    output logic               test_has_ended
);

    import qsys_epcs_nios2_oci_dct_pkg::*;

    localparam int BUF_W = 2 * SLOTS;

    dct_state_t       state;
    logic [BUF_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       grant;
    logic [1:0]       atom;
    logic             room;
    logic             accept;
    logic             full;
    logic             flush_pend;
    logic             out_free;
    logic             transfer;
    logic [BUF_W-1:0] acc_base;
    logic [BUF_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_next;

    qsys_epcs_nios2_oci_rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({dt_valid, it_valid}),
        .accept  (accept),
        .grant   (grant)
    );

    // Readys never see out_ready: a full accumulator simply waits for the next cycle.
    assign room       = (state == ST_RUN) && (cnt < CNT_W'(SLOTS));
    assign it_ready   = room & grant[0];
    assign dt_ready   = room & grant[1];
    assign accept     = (it_ready & it_valid) | (dt_ready & dt_valid);
    assign atom       = grant[1] ? dt_atom : it_atom;

    assign full       = (cnt == CNT_W'(SLOTS));
    assign flush_pend = (state == ST_FLUSH) || (state == ST_STOP_DRAIN);
    assign out_free   = !out_valid || out_ready;
    assign transfer   = out_free && (full || (flush_pend && (cnt != '0)));

    always_comb begin
        acc_base = transfer ? '0 : acc;
        cnt_base = transfer ? '0 : cnt;
        acc_next = acc_base;
        cnt_next = cnt_base;
        if (accept) begin
            acc_next = acc_base | (BUF_W'(atom) << {cnt_base, 1'b0});
            cnt_next = cnt_base + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc        <= '0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            dct_buffer <= '0;
            dct_count  <= '0;
        end else begin
            acc <= acc_next;
            cnt <= cnt_next;
            if (transfer) begin
                out_valid  <= 1'b1;
                dct_buffer <= acc;
                dct_count  <= cnt;
            end else if (out_ready) begin
                out_valid  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_RUN;
            test_ending    <= 1'b0;
            test_has_ended <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (trace_stop) begin
                        state       <= ST_STOP_DRAIN;
                        test_ending <= 1'b1;
                    end else if (flush) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (trace_stop) begin
                        state       <= ST_STOP_DRAIN;
                        test_ending <= 1'b1;
                    end else if ((cnt == '0) || transfer) begin
                        state <= ST_RUN;
                    end
                end
                ST_STOP_DRAIN: begin
                    // Leave only once the partial buffer and the held word are both gone.
                    if ((cnt == '0) && !out_valid) begin
                        state          <= ST_STOPPED;
                        test_ending    <= 1'b0;
                        test_has_ended <= 1'b1;
                    end
                end
                ST_STOPPED: begin
                    if (trace_start) begin
                        state          <= ST_RUN;
                        test_has_ended <= 1'b0;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_qsys_epcs_nios2_oci_dct_packer.sv
// Self-checking bench for the DCT atom packer: directed scenarios plus random traffic
// compared each cycle against a queue-based reference of the packing rules.
module tb_qsys_epcs_nios2_oci_dct_packer;

    logic        clk;
    logic        reset_n;
    logic        it_valid;
    logic [1:0]  it_atom;
    logic        it_ready;
    logic        dt_valid;
    logic [1:0]  dt_atom;
    logic        dt_ready;
    logic        flush;
    logic        trace_stop;
    logic        trace_start;
    logic        out_valid;
    logic        out_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_ending;
    logic        test_has_ended;

    int total = 0;
    int bad   = 0;

    localparam int M_RUN = 0, M_FLUSH = 1, M_SD = 2, M_STOPPED = 3;

    int          m_mode;
    logic [1:0]  m_atoms[$];
    logic [33:0] m_words[$];
    bit          m_prefer_dt;
    bit          m_te;
    bit          m_the;

    qsys_epcs_nios2_oci_dct_packer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .it_valid       (it_valid),
        .it_atom        (it_atom),
        .it_ready       (it_ready),
        .dt_valid       (dt_valid),
        .dt_atom        (dt_atom),
        .dt_ready       (dt_ready),
        .flush          (flush),
        .trace_stop     (trace_stop),
        .trace_start    (trace_start),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [29:0] packed_acc();
        logic [29:0] v = '0;
        for (int k = 0; k < m_atoms.size(); k++) begin
            v = v | (30'(m_atoms[k]) << (2 * k));
        end
        return v;
    endfunction

    task automatic model_reset();
        m_mode      = M_RUN;
        m_atoms.delete();
        m_words.delete();
        m_prefer_dt = 1'b0;
        m_te        = 1'b0;
        m_the       = 1'b0;
    endtask

    // One clock: check outputs mid-cycle against the reference, then advance the reference.
    task automatic cycle();
        bit room, g_dt, e_it, e_dt, flushing, free, xfer, had_word;
        int n;
        @(negedge clk);
        room = (m_mode == M_RUN) && (m_atoms.size() < 15);
        g_dt = (it_valid && dt_valid) ? m_prefer_dt : dt_valid;
        e_it = room && it_valid && !g_dt;
        e_dt = room && dt_valid && g_dt;
        chk("it_ready", 64'(it_ready), 64'(e_it));
        chk("dt_ready", 64'(dt_ready), 64'(e_dt));
        chk("out_valid", 64'(out_valid), 64'(m_words.size() != 0));
        if (m_words.size() != 0) chk("word", 64'({dct_count, dct_buffer}), 64'(m_words[0]));
        chk("test_ending", 64'(test_ending), 64'(m_te));
        chk("test_has_ended", 64'(test_has_ended), 64'(m_the));

        n        = m_atoms.size();
        had_word = (m_words.size() != 0);
        flushing = (m_mode == M_FLUSH) || (m_mode == M_SD);
        free     = !had_word || out_ready;
        xfer     = free && ((n == 15) || (flushing && n > 0));
        if (had_word && out_ready) void'(m_words.pop_front());
        if (xfer) begin
            m_words.push_back({4'(n), packed_acc()});
            m_atoms.delete();
        end
        if (e_it) begin
            m_atoms.push_back(it_atom);
            m_prefer_dt = 1'b1;
        end
        if (e_dt) begin
            m_atoms.push_back(dt_atom);
            m_prefer_dt = 1'b0;
        end
        case (m_mode)
            M_RUN: begin
                if (trace_stop) begin m_mode = M_SD; m_te = 1'b1; end
                else if (flush) m_mode = M_FLUSH;
            end
            M_FLUSH: begin
                if (trace_stop) begin m_mode = M_SD; m_te = 1'b1; end
                else if (n == 0 || xfer) m_mode = M_RUN;
            end
            M_SD: begin
                if (n == 0 && !had_word) begin
                    m_mode = M_STOPPED; m_te = 1'b0; m_the = 1'b1;
                end
            end
            default: begin
                if (trace_start) begin m_mode = M_RUN; m_the = 1'b0; end
            end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int iv, input int ia, input int dv, input int da,
                         input int fl, input int st, input int sa, input int ordy);
        it_valid    = 1'(iv);
        it_atom     = 2'(ia);
        dt_valid    = 1'(dv);
        dt_atom     = 2'(da);
        flush       = 1'(fl);
        trace_stop  = 1'(st);
        trace_start = 1'(sa);
        out_ready   = 1'(ordy);
        cycle();
    endtask

    initial begin
        reset_n     = 1'b0;
        it_valid    = 1'b0;
        it_atom     = 2'd0;
        dt_valid    = 1'b0;
        dt_atom     = 2'd0;
        flush       = 1'b0;
        trace_stop  = 1'b0;
        trace_start = 1'b0;
        out_ready   = 1'b0;
        model_reset();
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_buffer", 64'(dct_buffer), 64'd0);
        chk("rst_count", 64'(dct_count), 64'd0);
        chk("rst_ending", 64'(test_ending), 64'd0);
        chk("rst_ended", 64'(test_has_ended), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Fifteen instruction atoms 0,1,2,3,... fill one word; the next atom starts a fresh buffer.
        for (int k = 0; k < 15; k++) drive(1, k % 4, 0, 0, 0, 0, 0, 1);
        drive(1, 1, 0, 0, 0, 0, 0, 1);
        chk("full_word_valid", 64'(out_valid), 64'd1);
        chk("full_word", 64'({dct_count, dct_buffer}), {30'd0, 4'd15, 30'h24E4E4E4});
        drive(1, 1, 0, 0, 0, 0, 0, 1);

        // Both requesters contending, then data trace alone.
        for (int k = 0; k < 8; k++) drive(1, 2, 1, 3, 0, 0, 0, 1);
        for (int k = 0; k < 5; k++) drive(0, 0, 1, 2, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);

        // Four atoms then flush: partial word with zeroed upper slots.
        for (int k = 0; k < 4; k++) drive(1, 3 - k, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        chk("flush_count", 64'(dct_count), 64'd4);
        chk("flush_upper", 64'(dct_buffer[29:8]), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd1);
        // Flush with an empty accumulator.
        drive(0, 0, 0, 0, 1, 0, 0, 1);
        drive(1, 2, 0, 0, 0, 0, 0, 1);
        drive(1, 2, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);

        // Output stalled while a second buffer fills.
        for (int k = 0; k < 15; k++) drive(1, 3, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 17; k++) drive(0, 0, 1, 1, 0, 0, 0, 0);
        chk("stall_word", 64'({dct_count, dct_buffer}), {30'd0, 4'd15, 30'h3FFFFFFF});
        chk("stall_dt_ready", 64'(dt_ready), 64'd0);
        for (int k = 0; k < 4; k++) drive(0, 0, 0, 0, 0, 0, 0, 1);

        // Seven atoms then stop; valids ignored until start.
        for (int k = 0; k < 7; k++) drive(1, k % 4, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 1, 0, 1);
        for (int k = 0; k < 6; k++) drive(1, 1, 1, 2, 0, 0, 0, 1);
        chk("stopped", 64'(test_has_ended), 64'd1);
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        drive(1, 1, 1, 2, 0, 0, 0, 1);
        drive(1, 1, 1, 2, 0, 0, 0, 1);

        for (int i = 0; i < 400; i++) begin
            drive(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 31) == 0), int'($urandom_range(0, 99) == 0),
                  int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 9) < 7));
        end

        // Asynchronous reset with a held word and a partial buffer.
        for (int k = 0; k < 6; k++) drive(0, 0, 0, 0, 0, 0, 1, 1);
        for (int k = 0; k < 3; k++) drive(1, 2, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 3, 0, 0, 0, 0);
        drive(0, 0, 1, 3, 0, 0, 0, 0);
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        dt_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_buffer", 64'(dct_buffer), 64'd0);
        chk("arst_count", 64'(dct_count), 64'd0);
        chk("arst_ending", 64'(test_ending), 64'd0);
        chk("arst_ended", 64'(test_has_ended), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) drive(0, 0, 0, 0, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
